sram_bank_arbiter: RTL and testbench

Controller that shares one 2-port 16x32 SRAM bank between two requesters (requester 0 = fetch, requester 1 = datapath). It arbitrates requests and converts 5-bit addresses to the bank's one-hot wordlines. It sequences single-cycle ReadEn/WriteEn pulses and returns read data with a valid strobe. The bank has one shared write-data bus, writes the same data to both selected rows, decodes only rows 1..30, and holds row 0 at zero. This controller hides those properties from requesters.

---
 rtl/sram_bank_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter
//   Shares one 2-port 16x32 SRAM bank between requester 0 (fetch) and
//   requester 1 (datapath). It arbitrates, decodes 5-bit addresses to
//   one-hot wordlines, sequences the ReadEn/WriteEn pulse and returns read
//   data with a valid strobe.
// Ports
//   srclkpos, rst_n            : clock (rising edge), async active-low reset
//   req/we/addr/wdata[0,1]     : request side; fields stable until gnt
//   gnt/err[0,1]               : accept pulse; err when addr = 31
//   rvalid/rdata[0,1]          : read return; rdata held until next rvalid
//   busy                       : FSM outside IDLE
//   sram_word{A,B}, sram_ReadEn, sram_WriteEn, sram_in : bank controls
//   sram_out{A,B}              : bank read data
module sram_bank_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        srclkpos,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        err0,
  output logic        err1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic [31:0] sram_wordA,
  output logic [31:0] sram_wordB,
  output logic        sram_ReadEn,
  output logic        sram_WriteEn,
  output logic [15:0] sram_in,
  input  logic [15:0] sram_outA,
  input  logic [15:0] sram_outB
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RECOVER} state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cap_a_q, cap_a_d;   // port A read in flight for requester 0
  logic        cap_b_q, cap_b_d;   // port B read in flight for requester 1
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [31:0] word_a_q, word_a_d, word_b_q, word_b_d;
  logic        ren_q, ren_d, wen_q, wen_d;
  logic [15:0] sin_q, sin_d;

  logic idle, contested, g0, g1, slow0, slow1;
  logic [4:0]  waddr;
  logic [15:0] wdat;

  assign idle      = (state_q == S_IDLE);
  // A write shares the single write-data bus, so any write forces a single grant.
  assign contested = req0 & req1 & (we0 | we1);
  // Gated by rst_n so outputs read zero while reset is held.
  assign g0        = rst_n & idle & req0 & (~contested | ~rr_q);
  assign g1        = rst_n & idle & req1 & (~contested |  rr_q);
  // Rows 0 and 31 are not backed by the bank: answered without an access.
  assign slow0     = g0 & (addr0 != 5'd0) & (addr0 != 5'd31);
  assign slow1     = g1 & (addr1 != 5'd0) & (addr1 != 5'd31);
  assign waddr     = slow0 ? addr0  : addr1;
  assign wdat      = slow0 ? wdata0 : wdata1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    word_a_d  = word_a_q;
    word_b_d  = word_b_q;
    ren_d     = 1'b0;
    wen_d     = 1'b0;
    sin_d     = sin_q;
    case (state_q)
      S_IDLE: begin
        word_a_d = '0;
        word_b_d = '0;
        sin_d    = '0;
        cap_a_d  = 1'b0;
        cap_b_d  = 1'b0;
        if (contested) rr_d = ~rr_q;
        if (g0 & ~we0 & ~slow0) begin rvalid0_d = 1'b1; rdata0_d = '0; end
        if (g1 & ~we1 & ~slow1) begin rvalid1_d = 1'b1; rdata1_d = '0; end
        if (slow0 | slow1) begin
          state_d = S_ISSUE;
          // A slow write is always the only grant this cycle.
          if ((slow0 & we0) | (slow1 & we1)) begin
            wen_d    = 1'b1;
            word_a_d = 32'd1 << waddr;
            word_b_d = 32'd1 << waddr;
            sin_d    = wdat;
          end else begin
            ren_d    = 1'b1;
            word_a_d = slow0 ? (32'd1 << addr0) : '0;
            word_b_d = slow1 ? (32'd1 << addr1) : '0;
            cap_a_d  = slow0;
            cap_b_d  = slow1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_RECOVER;
        cnt_d   = 3'(READ_LAT - 1);
      end
      S_RECOVER: begin
        if (cnt_q == 3'd0) begin
          state_d  = S_IDLE;
          word_a_d = '0;
          word_b_d = '0;
          sin_d    = '0;
          if (cap_a_q) begin rvalid0_d = 1'b1; rdata0_d = sram_outA; end
          if (cap_b_q) begin rvalid1_d = 1'b1; rdata1_d = sram_outB; end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge srclkpos or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      cap_a_q   <= 1'b0;
      cap_b_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      word_a_q  <= '0;
      word_b_q  <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      sin_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      word_a_q  <= word_a_d;
      word_b_q  <= word_b_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      sin_q     <= sin_d;
    end
  end

  assign gnt0         = g0;
  assign gnt1         = g1;
  assign err0         = g0 & (addr0 == 5'd31);
  assign err1         = g1 & (addr1 == 5'd31);
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign busy         = ~idle;
  assign sram_wordA   = word_a_q;
  assign sram_wordB   = word_b_q;
  assign sram_ReadEn  = ren_q;
  assign sram_WriteEn = wen_q;
  assign sram_in      = sin_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench: one instance at READ_LAT=1 and one at READ_LAT=3 share the
// request stimulus; each drives its own behavioural bank model.
module tb_sram_bank_arbiter;

  logic        srclkpos = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1, busy, ren, wen;
  logic [15:0] rdata0, rdata1, sin, outa, outb;
  logic [31:0] worda, wordb;

  logic        gnt0_3, gnt1_3, err0_3, err1_3, rvalid0_3, rvalid1_3, busy_3, ren_3, wen_3;
  logic [15:0] rdata0_3, rdata1_3, sin_3, outa_3, outb_3;
  logic [31:0] worda_3, wordb_3;

  int n_chk = 0;
  int n_pass = 0;

  always #5 srclkpos = ~srclkpos;

  sram_bank_arbiter #(.READ_LAT(1)) u_dut (
    .srclkpos(srclkpos), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .sram_wordA(worda), .sram_wordB(wordb),
    .sram_ReadEn(ren), .sram_WriteEn(wen), .sram_in(sin),
    .sram_outA(outa), .sram_outB(outb)
  );

  sram_bank_arbiter #(.READ_LAT(3)) u_dut3 (
    .srclkpos(srclkpos), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_3), .gnt1(gnt1_3), .err0(err0_3), .err1(err1_3),
    .rvalid0(rvalid0_3), .rvalid1(rvalid1_3), .rdata0(rdata0_3), .rdata1(rdata1_3),
    .busy(busy_3), .sram_wordA(worda_3), .sram_wordB(wordb_3),
    .sram_ReadEn(ren_3), .sram_WriteEn(wen_3), .sram_in(sin_3),
    .sram_outA(outa_3), .sram_outB(outb_3)
  );

  // Bank models: rows 1..30 writable, read data registered on ReadEn.
  logic [15:0] mem1 [32];
  logic [15:0] mem3 [32];

  function automatic logic [15:0] pick(input logic [15:0] m [32], input logic [31:0] w);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) if (w[i]) v = m[i];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem1[i] <= (i == 0 || i == 31) ? 16'h0 : 16'h1000 + 16'(i);
      mem3[i] <= (i == 0 || i == 31) ? 16'h0 : 16'h1000 + 16'(i);
    end
    outa <= '0; outb <= '0; outa_3 <= '0; outb_3 <= '0;
  end

  always @(posedge srclkpos) begin
    if (wen) for (int i = 1; i < 31; i++) if (worda[i] | wordb[i]) mem1[i] <= sin;
    if (ren) begin outa <= pick(mem1, worda); outb <= pick(mem1, wordb); end
  end

  always @(posedge srclkpos) begin
    if (wen_3) for (int i = 1; i < 31; i++) if (worda_3[i] | wordb_3[i]) mem3[i] <= sin_3;
    if (ren_3) begin outa_3 <= pick(mem3, worda_3); outb_3 <= pick(mem3, wordb_3); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge srclkpos);
    #1;
  endtask

  int ng;
  int lat;
  logic seen;

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // Reset: outputs zero, gnt suppressed even with a request present
    cyc(); req0 = 1; addr0 = 5'd5; #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_worda", worda, 0);
    chk("rst_ren", ren, 0);
    chk("rst_rvalid0", rvalid0, 0);
    req0 = 0;
    cyc(); rst_n = 1'b1;
    cyc();

    // Write BEEF to row 5 from requester 1
    req1 = 1; we1 = 1; addr1 = 5'd5; wdata1 = 16'hBEEF; #1;
    chk("w_gnt1", gnt1, 1);
    chk("w_gnt0", gnt0, 0);
    chk("w_wen_T", wen, 0);
    cyc(); req1 = 0; we1 = 0;
    chk("w_wen_T1", wen, 1);
    chk("w_ren_T1", ren, 0);
    chk("w_worda", worda, 32'h20);
    chk("w_wordb", wordb, 32'h20);
    chk("w_sin", sin, 16'hBEEF);
    chk("w_busy_T1", busy, 1);
    cyc();
    chk("w_wen_T2", wen, 0);
    chk("w_busy_T2", busy, 1);
    chk("w_worda_hold", worda, 32'h20);
    cyc();
    chk("w_busy_T3", busy, 0);
    chk("w_worda_T3", worda, 0);
    chk("w_no_rvalid", rvalid1, 0);

    // Read row 5 back on requester 0
    req0 = 1; addr0 = 5'd5; #1;
    chk("r_gnt0", gnt0, 1);
    cyc(); req0 = 0;
    chk("r_ren_T1", ren, 1);
    chk("r_worda", worda, 32'h20);
    chk("r_wordb", wordb, 0);
    chk("r_busy_T1", busy, 1);
    cyc();
    chk("r_ren_T2", ren, 0);
    chk("r_busy_T2", busy, 1);
    chk("r_rvalid_T2", rvalid0, 0);
    cyc();
    chk("r_rvalid_T3", rvalid0, 1);
    chk("r_rdata", rdata0, 16'hBEEF);
    chk("r_busy_T3", busy, 0);
    cyc();
    chk("r_rvalid_T4", rvalid0, 0);
    chk("r_rdata_hold", rdata0, 16'hBEEF);

    // Simultaneous reads on both ports
    req0 = 1; addr0 = 5'd3; req1 = 1; addr1 = 5'd7; #1;
    chk("rr_gnt_both", {gnt0, gnt1}, 2'b11);
    cyc(); req0 = 0; req1 = 0;
    chk("rr_worda", worda, 32'h8);
    chk("rr_wordb", wordb, 32'h80);
    chk("rr_ren", ren, 1);
    cyc();
    cyc();
    chk("rr_rvalid_both", {rvalid0, rvalid1}, 2'b11);
    chk("rr_rdata0", rdata0, 16'h1003);
    chk("rr_rdata1", rdata1, 16'h1007);

    // Contested writes held for four grants: order 0,1,0,1
    cyc();
    req0 = 1; we0 = 1; addr0 = 5'd10; wdata0 = 16'hAAAA;
    req1 = 1; we1 = 1; addr1 = 5'd11; wdata1 = 16'h5555; #1;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      if (gnt0 | gnt1) begin
        chk("cont_order", {gnt0, gnt1}, (ng % 2 == 0) ? 2'b10 : 2'b01);
        ng++;
      end
      if (ng == 4) break;
      cyc();
    end
    chk("cont_grants", ng, 4);
    cyc(); req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    cyc();
    cyc();
    req0 = 1; addr0 = 5'd10; req1 = 1; addr1 = 5'd11; #1;
    cyc(); req0 = 0; req1 = 0;
    cyc();
    cyc();
    chk("cont_rdata0", rdata0, 16'hAAAA);
    chk("cont_rdata1", rdata1, 16'h5555);

    // Fast path: read row 0, write row 31
    cyc();
    req0 = 1; addr0 = 5'd0; #1;
    chk("fp_gnt0", gnt0, 1);
    chk("fp_err0", err0, 0);
    cyc(); req0 = 0;
    chk("fp_rvalid0", rvalid0, 1);
    chk("fp_rdata0", rdata0, 0);
    chk("fp_no_ren", ren, 0);
    chk("fp_busy", busy, 0);
    req1 = 1; we1 = 1; addr1 = 5'd31; wdata1 = 16'h7777; #1;
    chk("fp_gnt1", gnt1, 1);
    chk("fp_err1", err1, 1);
    cyc(); req1 = 0; we1 = 0;
    chk("fp_no_wen", wen, 0);
    chk("fp_busy_w", busy, 0);
    chk("fp_no_rvalid1", rvalid1, 0);
    repeat (6) cyc();

    // Reset during RECOVER of a read (READ_LAT=3 instance)
    req0 = 1; addr0 = 5'd5; #1;
    chk("rr3_gnt0", gnt0_3, 1);
    cyc(); req0 = 0;
    cyc();
    chk("rr3_busy_pre", busy_3, 1);
    rst_n = 1'b0; #1;
    chk("rr3_busy_rst", busy_3, 0);
    chk("rr3_worda_rst", worda_3, 0);
    chk("rr3_ren_rst", ren_3, 0);
    chk("rr1_busy_rst", busy, 0);
    cyc();
    cyc(); rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      cyc();
      if (rvalid0 | rvalid0_3 | ren_3 | ren) seen = 1'b1;
    end
    chk("rr3_dropped", seen, 0);

    req1 = 1; we1 = 1; addr1 = 5'd9; wdata1 = 16'h1234; #1;
    chk("rr3_wgnt", gnt1_3, 1);
    cyc(); req1 = 0; we1 = 0;
    repeat (6) cyc();
    req0 = 1; addr0 = 5'd9; #1;
    chk("rr3_rgnt", gnt0_3, 1);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 1) req0 = 0;
      if (rvalid0_3) begin lat = c; break; end
    end
    chk("rr3_latency", lat, 5);
    chk("rr3_rdata", rdata0_3, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
